// File: rtl/seq_pattern_tx.sv
`default_nettype none
// ============================================================================
// Module   : seq_pattern_tx
// Summary  : MSB-first serial pattern transmitter with a run-length model that
//            predicts the 0000/1111 detector output (z_exp) for the stream.
// Revision : 1.0
// ============================================================================
module seq_pattern_tx #(
    parameter int WIDTH = 16,
    parameter int RUN   = 4
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   load,
    input  logic [WIDTH-1:0]       pattern,
    input  logic [$clog2(WIDTH):0] len,
    input  logic                   loop,
    input  logic                   start,
    input  logic                   stop,
    output logic                   w,
    output logic                   w_valid,
    output logic                   busy,
    output logic                   done,
    output logic                   z_exp
);
    localparam int C_IW = $clog2(WIDTH);
    localparam int C_LW = C_IW + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [WIDTH-1:0]  r_shreg;
    logic [C_LW-1:0]   r_len;
    logic              r_loop;
    logic [C_IW-1:0]   r_idx;
    logic              r_w;
    logic              r_w_valid;
    logic              r_done;
    logic              r_prev;
    logic [2:0]        r_run;
    logic              r_z;

    logic [C_LW-1:0]   w_len_in;
    logic [C_LW-1:0]   w_len_cur;
    logic [C_LW-1:0]   w_len_start;
    logic [WIDTH-1:0]  w_pat_start;
    logic [C_IW-1:0]   w_last_cur;
    logic [C_IW-1:0]   w_last_start;
    logic [C_IW-1:0]   w_idx_nxt;
    logic              w_loop_nxt;
    logic              w_w_nxt;
    logic              w_valid_nxt;
    logic              w_done_nxt;
    logic [2:0]        w_run_nxt;

    // A stored length of 0 only exists before the first load and means WIDTH.
    assign w_len_in     = (len == '0 || len > C_LW'(WIDTH)) ? C_LW'(WIDTH) : len;
    assign w_len_cur    = (r_len == '0) ? C_LW'(WIDTH) : r_len;
    assign w_len_start  = load ? w_len_in : w_len_cur;
    assign w_pat_start  = load ? pattern : r_shreg;
    assign w_last_cur   = C_IW'(w_len_cur - C_LW'(1));
    assign w_last_start = C_IW'(w_len_start - C_LW'(1));

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_loop_nxt  = r_loop;
        w_w_nxt     = 1'b0;
        w_valid_nxt = 1'b0;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_SHIFT;
                    w_idx_nxt   = w_last_start;
                    w_loop_nxt  = loop;
                    w_w_nxt     = w_pat_start[w_last_start];
                    w_valid_nxt = 1'b1;
                end
            end
            S_SHIFT: begin
                if (stop) begin
                    w_state_nxt = S_IDLE;
                end else if (r_idx != '0) begin
                    w_idx_nxt   = r_idx - C_IW'(1);
                    w_w_nxt     = r_shreg[r_idx - C_IW'(1)];
                    w_valid_nxt = 1'b1;
                end else if (r_loop) begin
                    w_idx_nxt   = w_last_cur;
                    w_w_nxt     = r_shreg[w_last_cur];
                    w_valid_nxt = 1'b1;
                end else begin
                    w_state_nxt = S_DONE;
                    w_done_nxt  = 1'b1;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_loop    <= 1'b0;
            r_w       <= 1'b0;
            r_w_valid <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_idx     <= w_idx_nxt;
            r_loop    <= w_loop_nxt;
            r_w       <= w_w_nxt;
            r_w_valid <= w_valid_nxt;
            r_done    <= w_done_nxt;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_shreg <= '0;
            r_len   <= '0;
        end else if (r_state == S_IDLE && load) begin
            r_shreg <= pattern;
            r_len   <= w_len_in;
        end
    end

    // r_run==0 marks the first valid bit after a gap; the count saturates at RUN.
    always_comb begin
        if (r_run == 3'd0 || r_w != r_prev)
            w_run_nxt = 3'd1;
        else if (r_run >= 3'(RUN))
            w_run_nxt = 3'(RUN);
        else
            w_run_nxt = r_run + 3'd1;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_run  <= 3'd0;
            r_prev <= 1'b0;
            r_z    <= 1'b0;
        end else if (r_w_valid) begin
            r_run  <= w_run_nxt;
            r_prev <= r_w;
            r_z    <= (w_run_nxt == 3'(RUN));
        end else begin
            r_run  <= 3'd0;
            r_prev <= 1'b0;
            r_z    <= 1'b0;
        end
    end

    assign w       = r_w;
    assign w_valid = r_w_valid;
    assign busy    = (r_state != S_IDLE);
    assign done    = r_done;
    assign z_exp   = r_z;

endmodule
`default_nettype wire

// File: tb/tb_seq_pattern_tx.sv
`default_nettype none
// Self-checking bench for seq_pattern_tx: expected per-cycle outputs are built
// from the bit stream and a sliding window of the last RUN bits.
module tb_seq_pattern_tx;
    localparam int W   = 16;
    localparam int RUN = 4;

    logic         clock = 1'b0;
    logic         resetn = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] pattern = '0;
    logic [4:0]   len = '0;
    logic         loop = 1'b0;
    logic         start = 1'b0;
    logic         stop = 1'b0;
    logic         w, w_valid, busy, done, z_exp;

    int checks = 0;
    int errors = 0;
    logic [4:0]   exp_q[$];
    logic [W-1:0] m_pat = '0;
    int           m_len = W;

    // Observation vector: {busy, w_valid, w, done, z_exp}
    wire [4:0] obs = {busy, w_valid, w, done, z_exp};

    seq_pattern_tx #(.WIDTH(W), .RUN(RUN)) dut (
        .clock(clock), .resetn(resetn), .load(load), .pattern(pattern),
        .len(len), .loop(loop), .start(start), .stop(stop),
        .w(w), .w_valid(w_valid), .busy(busy), .done(done), .z_exp(z_exp)
    );

    always #5 clock = ~clock;

    function automatic int eff_len(input int l);
        return (l == 0 || l > W) ? W : l;
    endfunction

    // Expected outputs for cycles 1.. after the start edge.
    task automatic model_build(input logic [W-1:0] pat, input int L, input bit lp, input int stop_cyc);
        int nb;
        bit stopped;
        bit same;
        bit s[$];
        logic [4:0] e;
        exp_q.delete();
        if (lp || (stop_cyc >= 1 && stop_cyc <= L)) begin
            nb = stop_cyc; stopped = 1'b1;
        end else begin
            nb = L; stopped = 1'b0;
        end
        for (int k = 0; k < nb; k++) s.push_back(pat[L-1-(k%L)]);
        for (int c = 1; c <= nb + 3; c++) begin
            e = 5'b0;
            if (c <= nb) e = {1'b1, 1'b1, s[c-1], 1'b0, 1'b0};
            else if (c == nb + 1 && !stopped) e = 5'b10010;
            if (c >= RUN + 1 && c - 1 <= nb) begin
                same = 1'b1;
                for (int j = c - 1 - RUN; j < c - 1; j++) if (s[j] != s[c-2]) same = 1'b0;
                e[0] = same;
            end
            exp_q.push_back(e);
        end
    endtask

    task automatic drive_start(input bit ld, input logic [W-1:0] pat, input int l, input bit lp);
        @(negedge clock);
        load = ld; start = 1'b1; pattern = pat; len = 5'(l); loop = lp;
        if (ld) begin m_pat = pat; m_len = eff_len(l); end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clock);
        checks++;
        if (obs !== 5'b0) begin errors++; $display("FAIL reset_held got=%b exp=%b", obs, 5'b0); end
        resetn = 1'b1;
        repeat (3) @(negedge clock);
        checks++;
        if (obs !== 5'b0) begin errors++; $display("FAIL reset_idle got=%b exp=%b", obs, 5'b0); end
    endtask

    task automatic test_single_shot();
        drive_start(1'b1, 16'hF0F0, 0, 1'b0);
        model_build(m_pat, m_len, 1'b0, 0);
        for (int c = 1; c <= exp_q.size(); c++) begin
            @(negedge clock); load = 1'b0; start = 1'b0;
            checks++;
            if (obs !== exp_q[c-1]) begin errors++; $display("FAIL single_shot cyc=%0d got=%b exp=%b", c, obs, exp_q[c-1]); end
        end
    endtask

    task automatic test_alternating();
        drive_start(1'b1, 16'hAAAA, 8, 1'b0);
        model_build(m_pat, m_len, 1'b0, 0);
        for (int c = 1; c <= exp_q.size(); c++) begin
            @(negedge clock); load = 1'b0; start = 1'b0;
            checks++;
            if (obs !== exp_q[c-1]) begin errors++; $display("FAIL alternating cyc=%0d got=%b exp=%b", c, obs, exp_q[c-1]); end
        end
    endtask

    task automatic test_loop_wrap();
        logic [W-1:0] pats [3] = '{16'h0003, 16'h0007, 16'h0007};
        int           lens [3] = '{4, 4, 3};
        for (int t = 0; t < 3; t++) begin
            drive_start(1'b1, pats[t], lens[t], 1'b1);
            model_build(m_pat, m_len, 1'b1, 12);
            for (int c = 1; c <= exp_q.size(); c++) begin
                @(negedge clock); load = 1'b0; start = 1'b0;
                checks++;
                if (obs !== exp_q[c-1]) begin errors++; $display("FAIL loop_wrap%0d cyc=%0d got=%b exp=%b", t, c, obs, exp_q[c-1]); end
                stop = (c == 12);
            end
        end
    endtask

    task automatic test_ignored_controls();
        logic [W-1:0] p;
        p = W'($urandom);
        for (int t = 0; t < 2; t++) begin
            drive_start(t == 0, p, 16, 1'b0);
            model_build(p, 16, 1'b0, 0);
            for (int c = 1; c <= exp_q.size(); c++) begin
                @(negedge clock); load = 1'b0; start = 1'b0;
                checks++;
                if (obs !== exp_q[c-1]) begin errors++; $display("FAIL ignored_ctl%0d cyc=%0d got=%b exp=%b", t, c, obs, exp_q[c-1]); end
                if (c == 5) begin load = 1'b1; start = 1'b1; pattern = '0; len = 5'd4; end
            end
        end
    endtask

    task automatic test_async_reset();
        drive_start(1'b1, 16'hFFFF, 16, 1'b0);
        repeat (6) @(negedge clock);
        load = 1'b0; start = 1'b0;
        checks++;
        if (obs[4:3] !== 2'b11) begin errors++; $display("FAIL pre_reset_busy got=%b exp=%b", obs[4:3], 2'b11); end
        #2 resetn = 1'b0;
        #1;
        checks++;
        if (obs !== 5'b0) begin errors++; $display("FAIL async_reset got=%b exp=%b", obs, 5'b0); end
        @(negedge clock); resetn = 1'b1;
        m_pat = '0; m_len = W;
        drive_start(1'b0, W'($urandom), 0, 1'b0);
        model_build(m_pat, m_len, 1'b0, 0);
        for (int c = 1; c <= exp_q.size(); c++) begin
            @(negedge clock); load = 1'b0; start = 1'b0;
            checks++;
            if (obs !== exp_q[c-1]) begin errors++; $display("FAIL post_reset cyc=%0d got=%b exp=%b", c, obs, exp_q[c-1]); end
        end
    endtask

    task automatic test_load_start_clamp();
        drive_start(1'b1, 16'h000F, 20, 1'b0);
        model_build(16'h000F, 16, 1'b0, 0);
        for (int c = 1; c <= exp_q.size(); c++) begin
            @(negedge clock); load = 1'b0; start = 1'b0;
            checks++;
            if (obs !== exp_q[c-1]) begin errors++; $display("FAIL clamp cyc=%0d got=%b exp=%b", c, obs, exp_q[c-1]); end
        end
    endtask

    task automatic test_random();
        bit ld, lp;
        int sc;
        for (int t = 0; t < 25; t++) begin
            ld = ($urandom_range(0, 3) != 0);
            lp = $urandom_range(0, 1) == 1;
            drive_start(ld, W'($urandom), $urandom_range(0, 31), lp);
            if (lp) sc = $urandom_range(1, 3 * m_len);
            else    sc = ($urandom_range(0, 3) == 0) ? $urandom_range(1, m_len) : 0;
            model_build(m_pat, m_len, lp, sc);
            for (int c = 1; c <= exp_q.size(); c++) begin
                @(negedge clock); load = 1'b0; start = 1'b0;
                checks++;
                if (obs !== exp_q[c-1]) begin errors++; $display("FAIL random%0d cyc=%0d got=%b exp=%b", t, c, obs, exp_q[c-1]); end
                stop = (c == sc);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_shot();
        test_alternating();
        test_loop_wrap();
        test_ignored_controls();
        test_async_reset();
        test_load_start_clamp();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
